// File: rtl/uart_ext.sv
// uart_ext: parametrised UART with baud generator, TX/RX FIFOs, parity, stop-bit select and sticky errors.
// Ports:
//   clk, reset (async, active-low)
//   dvsr      baud divisor; a tick every dvsr+1 clocks, 16 ticks per bit
//   par_mode  00 none, 01 even, 10 odd, 11 none
//   stop2     transmit two stop bits
//   wr_uart/w_data  push a word into the TX FIFO
//   rd_uart/r_data  pop / show-ahead head of the RX FIFO
//   clr_err   clear the sticky error flags
//   rx, tx    serial pins
//   tx_full, tx_idle, rx_empty, parity_err, frame_err, overrun_err  status
module uart_ext_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic [W-1:0] w_data,
  output logic         empty,
  output logic         full,
  output logic [W-1:0] r_data
);
  logic [W-1:0] mem [2**AW];
  logic [AW-1:0] wptr, rptr, wnx, rnx;
  logic do_rd, do_wr;
  assign wnx = wptr + 1'b1;
  assign rnx = rptr + 1'b1;
  assign do_rd = rd & ~empty;
  // a full FIFO still accepts a write when the head is popped in the same cycle
  assign do_wr = wr & (~full | do_rd);
  assign r_data = mem[rptr];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wptr] <= w_data;
        wptr      <= wnx;
      end
      if (do_rd) rptr <= rnx;
      if (do_wr & ~do_rd) begin
        empty <= 1'b0;
        full  <= wnx == rptr;
      end else if (do_rd & ~do_wr) begin
        full  <= 1'b0;
        empty <= rnx == wptr;
      end
    end
  end
endmodule

module uart_ext #(
  parameter int DBIT       = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int DVSR_W     = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        par_mode,
  input  logic              stop2,
  input  logic              wr_uart,
  input  logic [DBIT-1:0]   w_data,
  input  logic              rd_uart,
  input  logic              clr_err,
  input  logic              rx,
  output logic              tx,
  output logic              tx_full,
  output logic              tx_idle,
  output logic              rx_empty,
  output logic [DBIT-1:0]   r_data,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [2:0] NLAST = 3'(DBIT - 1);
  logic [DVSR_W-1:0] cnt;
  logic tick;
  assign tick = cnt == dvsr;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= tick ? '0 : cnt + 1'b1;
  end
  logic tx_empty, tx_pop;
  logic [DBIT-1:0] tx_head;
  uart_ext_fifo #(.W(DBIT), .AW(ADDR_WIDTH)) tx_fifo (
    .clk(clk), .reset(reset), .rd(tx_pop), .wr(wr_uart), .w_data(w_data),
    .empty(tx_empty), .full(tx_full), .r_data(tx_head)
  );
  state_t ts, ts_n;
  logic [4:0] tsc, tsc_n;
  logic [2:0] tn, tn_n;
  logic [DBIT-1:0] tsh, tsh_n;
  logic tpb, tpb_n, tpen, tpen_n, ts2, ts2_n, tx_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts   <= IDLE;
      tsc  <= '0;
      tn   <= '0;
      tsh  <= '0;
      tpb  <= 1'b0;
      tpen <= 1'b0;
      ts2  <= 1'b0;
      tx   <= 1'b1;
    end else begin
      ts   <= ts_n;
      tsc  <= tsc_n;
      tn   <= tn_n;
      tsh  <= tsh_n;
      tpb  <= tpb_n;
      tpen <= tpen_n;
      ts2  <= ts2_n;
      tx   <= tx_n;
    end
  end
  // frame settings are captured when a word is taken so mid-frame changes wait for the next frame
  always_comb begin
    ts_n   = ts;
    tsc_n  = tsc;
    tn_n   = tn;
    tsh_n  = tsh;
    tpb_n  = tpb;
    tpen_n = tpen;
    ts2_n  = ts2;
    case (ts)
      IDLE: if (!tx_empty) begin
        ts_n   = START;
        tsc_n  = '0;
        tsh_n  = tx_head;
        tpb_n  = ^tx_head ^ (par_mode == 2'b10);
        tpen_n = par_mode == 2'b01 || par_mode == 2'b10;
        ts2_n  = stop2;
      end
      START: if (tick) begin
        tsc_n = tsc + 1'b1;
        if (tsc == 5'd15) begin
          ts_n  = DATA;
          tsc_n = '0;
          tn_n  = '0;
        end
      end
      DATA: if (tick) begin
        tsc_n = tsc + 1'b1;
        if (tsc == 5'd15) begin
          tsc_n = '0;
          tsh_n = tsh >> 1;
          tn_n  = tn + 1'b1;
          if (tn == NLAST) ts_n = tpen ? PARITY : STOP;
        end
      end
      PARITY: if (tick) begin
        tsc_n = tsc + 1'b1;
        if (tsc == 5'd15) begin
          ts_n  = STOP;
          tsc_n = '0;
        end
      end
      STOP: if (tick) begin
        tsc_n = tsc + 1'b1;
        if (tsc == (ts2 ? 5'd31 : 5'd15)) begin
          ts_n  = IDLE;
          tsc_n = '0;
        end
      end
      default: ts_n = IDLE;
    endcase
  end
  always_comb begin
    tx_pop = ts == IDLE && !tx_empty;
    tx_n   = ts == START ? 1'b0 : ts == DATA ? tsh[0] : ts == PARITY ? tpb : 1'b1;
  end
  assign tx_idle = tx_empty && ts == IDLE;
  logic [1:0] sync;
  logic rx_s;
  assign rx_s = sync[1];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], rx};
  end
  state_t rs, rs_n;
  logic [3:0] rsc, rsc_n;
  logic [2:0] rn, rn_n;
  logic [DBIT-1:0] rb, rb_n;
  logic rpen, rpen_n, rodd, rodd_n;
  logic rx_done, rx_full, par_set, frm_set, ovr_set;
  uart_ext_fifo #(.W(DBIT), .AW(ADDR_WIDTH)) rx_fifo (
    .clk(clk), .reset(reset), .rd(rd_uart), .wr(rx_done), .w_data(rb),
    .empty(rx_empty), .full(rx_full), .r_data(r_data)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs   <= IDLE;
      rsc  <= '0;
      rn   <= '0;
      rb   <= '0;
      rpen <= 1'b0;
      rodd <= 1'b0;
    end else begin
      rs   <= rs_n;
      rsc  <= rsc_n;
      rn   <= rn_n;
      rb   <= rb_n;
      rpen <= rpen_n;
      rodd <= rodd_n;
    end
  end
  // the start bit is re-checked mid-bit; every later sample lands 16 ticks on, near bit centre
  always_comb begin
    rs_n   = rs;
    rsc_n  = rsc;
    rn_n   = rn;
    rb_n   = rb;
    rpen_n = rpen;
    rodd_n = rodd;
    case (rs)
      IDLE: if (!rx_s) begin
        rs_n   = START;
        rsc_n  = '0;
        rpen_n = par_mode == 2'b01 || par_mode == 2'b10;
        rodd_n = par_mode == 2'b10;
      end
      START: if (tick) begin
        rsc_n = rsc + 1'b1;
        if (rsc == 4'd7) begin
          rs_n  = rx_s ? IDLE : DATA;
          rsc_n = '0;
          rn_n  = '0;
        end
      end
      DATA: if (tick) begin
        rsc_n = rsc + 1'b1;
        if (rsc == 4'd15) begin
          rsc_n = '0;
          rb_n  = {rx_s, rb[DBIT-1:1]};
          rn_n  = rn + 1'b1;
          if (rn == NLAST) rs_n = rpen ? PARITY : STOP;
        end
      end
      PARITY: if (tick) begin
        rsc_n = rsc + 1'b1;
        if (rsc == 4'd15) begin
          rs_n  = STOP;
          rsc_n = '0;
        end
      end
      STOP: if (tick) begin
        rsc_n = rsc + 1'b1;
        if (rsc == 4'd15) begin
          rs_n  = IDLE;
          rsc_n = '0;
        end
      end
      default: rs_n = IDLE;
    endcase
  end
  always_comb begin
    rx_done = rs == STOP && tick && rsc == 4'd15;
    par_set = rs == PARITY && tick && rsc == 4'd15 && (rx_s != (^rb ^ rodd));
    frm_set = rx_done && !rx_s;
    ovr_set = rx_done && rx_full && !rd_uart;
  end
  // set wins over clear when both happen in one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      parity_err  <= par_set | (parity_err & ~clr_err);
      frame_err   <= frm_set | (frame_err & ~clr_err);
      overrun_err <= ovr_set | (overrun_err & ~clr_err);
    end
  end
endmodule

// File: tb/tb_uart_ext.sv
// tb_uart_ext: directed self-checking bench for uart_ext (DBIT=8, 4-deep FIFOs, dvsr=4 -> 80 clocks per bit).
module tb_uart_ext;
  logic clk = 1'b0, reset = 1'b0;
  logic [10:0] dvsr = 11'd4;
  logic [1:0] par_mode = 2'b00;
  logic stop2 = 1'b0, wr_uart = 1'b0, rd_uart = 1'b0, clr_err = 1'b0, rx = 1'b1;
  logic [7:0] w_data = 8'h00;
  logic tx, tx_full, tx_idle, rx_empty, parity_err, frame_err, overrun_err;
  logic [7:0] r_data;
  logic [15:0] b;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  uart_ext #(.DBIT(8), .ADDR_WIDTH(2), .DVSR_W(11)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .par_mode(par_mode), .stop2(stop2),
    .wr_uart(wr_uart), .w_data(w_data), .rd_uart(rd_uart), .clr_err(clr_err), .rx(rx),
    .tx(tx), .tx_full(tx_full), .tx_idle(tx_idle), .rx_empty(rx_empty), .r_data(r_data),
    .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic write(input logic [7:0] d);
    w_data = d;
    wr_uart = 1'b1;
    @(negedge clk);
    wr_uart = 1'b0;
  endtask
  task automatic pop();
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask
  task automatic cap_tx(input int nb, output logic [15:0] bits);
    int t = 0;
    bits = '0;
    while (tx !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("tx_start_wait", 16'(t < 3000), 16'd1);
    cyc(40);
    bits[0] = tx;
    for (int i = 1; i < nb; i++) begin
      cyc(80);
      bits[i] = tx;
    end
  endtask
  task automatic wait_idle(input int lim);
    int t = 0;
    while (tx_idle !== 1'b1 && t < lim) begin
      @(negedge clk);
      t++;
    end
    chk("tx_idle_wait", 16'(tx_idle), 16'd1);
  endtask
  task automatic send_rx(input logic [7:0] d, input logic pen, input logic pb, input logic sb);
    rx = 1'b0;
    cyc(80);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cyc(80);
    end
    if (pen) begin
      rx = pb;
      cyc(80);
    end
    rx = sb;
    cyc(sb ? 80 : 52);
    rx = 1'b1;
    cyc(sb ? 4 : 100);
  endtask
  initial begin
    cyc(3);
    reset = 1'b1;
    cyc(2);
    chk("rst_tx", 16'(tx), 16'd1);
    chk("rst_tx_full", 16'(tx_full), 16'd0);
    chk("rst_tx_idle", 16'(tx_idle), 16'd1);
    chk("rst_rx_empty", 16'(rx_empty), 16'd1);
    chk("rst_r_data", 16'(r_data), 16'd0);
    chk("rst_par", 16'(parity_err), 16'd0);
    chk("rst_frm", 16'(frame_err), 16'd0);
    chk("rst_ovr", 16'(overrun_err), 16'd0);
    write(8'h55);
    @(negedge clk);
    chk("tx_lat_k1", 16'(tx), 16'd1);
    @(negedge clk);
    chk("tx_lat_k2", 16'(tx), 16'd0);
    cap_tx(10, b);
    chk("tx_55_8n1", b, 16'h02AA);
    wait_idle(200);
    par_mode = 2'b01;
    write(8'h07);
    cap_tx(11, b);
    chk("tx_07_even", b, 16'h060E);
    wait_idle(200);
    par_mode = 2'b10;
    write(8'h07);
    cap_tx(11, b);
    chk("tx_07_odd", b, 16'h040E);
    wait_idle(200);
    par_mode = 2'b00;
    stop2 = 1'b1;
    write(8'h00);
    cap_tx(11, b);
    chk("tx_00_stop2", b, 16'h0600);
    chk("tx_stop2_busy", 16'(tx_idle), 16'd0);
    wait_idle(200);
    stop2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w_data = 8'(8'h11 * (i + 1));
      wr_uart = 1'b1;
      @(negedge clk);
      if (i == 3) chk("tx_full_w4", 16'(tx_full), 16'd0);
      if (i == 4) chk("tx_full_w5", 16'(tx_full), 16'd1);
      if (i == 5) chk("tx_full_w6", 16'(tx_full), 16'd1);
    end
    wr_uart = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cap_tx(10, b);
      chk("tx_queue", b, 16'h0200 | (16'(8'h11 * (j + 1)) << 1));
    end
    wait_idle(200);
    send_rx(8'h55, 1'b0, 1'b0, 1'b1);
    send_rx(8'hAA, 1'b0, 1'b0, 1'b1);
    send_rx(8'h00, 1'b0, 1'b0, 1'b1);
    chk("rx_not_empty", 16'(rx_empty), 16'd0);
    chk("rx_w0", 16'(r_data), 16'h55);
    pop();
    chk("rx_w1", 16'(r_data), 16'hAA);
    pop();
    chk("rx_w2", 16'(r_data), 16'h00);
    pop();
    chk("rx_drained", 16'(rx_empty), 16'd1);
    chk("rx_ok_par", 16'(parity_err), 16'd0);
    chk("rx_ok_frm", 16'(frame_err), 16'd0);
    chk("rx_ok_ovr", 16'(overrun_err), 16'd0);
    par_mode = 2'b01;
    send_rx(8'h07, 1'b1, 1'b0, 1'b1);
    chk("rx_par_err", 16'(parity_err), 16'd1);
    chk("rx_no_frm_yet", 16'(frame_err), 16'd0);
    send_rx(8'h03, 1'b1, 1'b0, 1'b0);
    chk("rx_frm_err", 16'(frame_err), 16'd1);
    chk("rx_bad_par_word", 16'(r_data), 16'h07);
    pop();
    chk("rx_bad_stop_word", 16'(r_data), 16'h03);
    pop();
    chk("rx_err_drained", 16'(rx_empty), 16'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_par", 16'(parity_err), 16'd0);
    chk("clr_frm", 16'(frame_err), 16'd0);
    par_mode = 2'b00;
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b0, 1'b0, 1'b1);
    chk("rx_overrun", 16'(overrun_err), 16'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("rx_ovr_word", 16'(r_data), 16'(i));
      pop();
    end
    chk("rx_ovr_drained", 16'(rx_empty), 16'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_ovr", 16'(overrun_err), 16'd0);
    rx = 1'b0;
    cyc(10);
    rx = 1'b1;
    cyc(200);
    chk("glitch_empty", 16'(rx_empty), 16'd1);
    chk("glitch_no_frm", 16'(frame_err), 16'd0);
    write(8'hA5);
    cyc(40);
    chk("pre_rst_tx", 16'(tx), 16'd0);
    chk("pre_rst_busy", 16'(tx_idle), 16'd0);
    reset = 1'b0;
    #1;
    chk("rst_mid_tx", 16'(tx), 16'd1);
    chk("rst_mid_idle", 16'(tx_idle), 16'd1);
    cyc(2);
    reset = 1'b1;
    cyc(200);
    chk("post_rst_tx", 16'(tx), 16'd1);
    chk("post_rst_idle", 16'(tx_idle), 16'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_ext.md
# uart_ext

Parametrised UART that supersedes the fixed 8N1 UART. It adds compile-time data width and FIFO depth, and run-time parity and stop-bit selection. It reports sticky parity, framing and overrun errors. It is self-contained: baud tick generator, TX/RX FIFOs and TX/RX state machines. It sits between the bus-side register block (rd/wr strobes) and the board pins.

## Interface
- DBIT, 8: data bits per frame, legal 5..8.
- ADDR_WIDTH, 2: FIFO address width; each FIFO holds 2**ADDR_WIDTH words.
- DVSR_W, 11: width of `dvsr`.
- clk  in  1  system clock.
- reset  in  1  one clock; reset is asynchronous and active-low.
- dvsr  in  DVSR_W  baud divisor; tick period = dvsr+1 cycles, 16 ticks per bit.
- par_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- stop2  in  1  0: one stop bit, 1: two stop bits (TX only).
- wr_uart  in  1  push `w_data` into TX FIFO.
- w_data  in  DBIT  transmit word.
- rd_uart  in  1  pop RX FIFO head.
- clr_err  in  1  clear all sticky error flags.
- rx  in  1  serial input, asynchronous.
- tx  out  1  serial output, registered.
- tx_full  out  1  TX FIFO full.
- tx_idle  out  1  TX FIFO empty and TX FSM idle.
- rx_empty  out  1  RX FIFO empty.
- r_data  out  DBIT  RX FIFO head (show-ahead).
- parity_err, frame_err, overrun_err  out  1 each  sticky error flags.

## Operation
**Reset values:** tx=1, tx_full=0, tx_idle=1, rx_empty=1, r_data=0, all error flags 0. Both FIFOs empty, both FSMs IDLE, baud counter 0, rx synchroniser =1.

**Baud generator**
- Counter runs 0..dvsr; tick when counter==dvsr, then wraps to 0.
- dvsr=0 gives a tick every cycle.

**FIFOs**
- Write accepted iff !full, or a pop occurs in the same cycle.
- Pop ignored when empty.
- Pointers wrap modulo 2**ADDR_WIDTH.
- Full/empty are registered.

**TX FSM: IDLE → START → DATA → PARITY → STOP**
- IDLE: when the FIFO is not empty, latch head into the shift register, pop the FIFO, latch par_mode/stop2, go to START.
- START: tx=0 for 16 ticks.
- DATA: DBIT bits, LSB first, 16 ticks each.
- PARITY: only if parity enabled. Even mode: bit = XOR of data bits. Odd mode: bit = its inverse.
- STOP: tx=1 for 16 ticks (32 if stop2), then IDLE.
- Back-to-back words: no idle gap beyond one clock.

**RX FSM: IDLE → START → DATA → PARITY → STOP**
- rx passes through a 2-FF synchroniser.
- IDLE: a synchronised 0 starts the frame and latches par_mode.
- START: after 7 ticks, re-sample. If rx=1, treat as a glitch and return to IDLE. Otherwise reset the tick count and go to DATA.
- DATA: sample every 16 ticks, DBIT bits LSB first.
- PARITY: sample one bit if enabled. On mismatch, set parity_err; the word is still kept.
- STOP: sample after 16 ticks. If 0, set frame_err; the word is still kept.
- On frame completion: push into the RX FIFO. If the FIFO is full, discard the word and set overrun_err.
- RX checks only one stop bit.

**Error flags**
- Set-dominant over clr_err in the same cycle.
- Remain set until clr_err.

**Mid-operation behaviour**
- par_mode/stop2 changes mid-frame take effect at the next frame.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronous), the frame is lost, FIFO contents are lost.

## Timing
- tx_full / rx_empty update the cycle after the edge that changes FIFO occupancy.
- TX latency:
  - wr_uart at edge k into an empty FIFO with an idle FSM → tx falls at edge k+2.
  - Start bit is 16 ticks, with the first tick possibly partial (±1 tick period).
- Frame length in ticks: 16·(1+DBIT+P+S), where P = parity enabled, S = 1 or 2.
- tx_idle rises the cycle after the final stop tick when the FIFO is empty.
- RX latency: the word appears at r_data and rx_empty falls 1 cycle after the stop-bit sample tick.
- rd_uart at edge k: r_data shows the next word (or holds stale data if now empty) after edge k.

## Test plan
- DBIT=8, dvsr=4, none/1 stop, write 0x55 → tx: 0,1,0,1,0,1,0,1,0,1, each bit 80 cycles; tx_idle high afterwards.
- par_mode=01, write 0x07 → parity bit 1. par_mode=10 → parity bit 0. stop2=1 → stop high 160 cycles.
- Write 5 words into a 4-deep TX FIFO with the FSM stalled, then the FIFO drains:
  - tx_full after the 4th write;
  - the 5th write is dropped... unless the FSM popped in that cycle, as specified.
- Drive rx frames 0x55, 0xAA, 0x00 (8N1) → RX FIFO holds 0x55, 0xAA, 0x00 in order; no error flags set.
- RX frame with wrong parity, then a frame with stop=0:
  - parity_err=1, then frame_err=1; words are stored;
  - clr_err clears both.
- Send 5 rx frames with no rd_uart → 4 stored, overrun_err=1. 10-cycle start glitch → no frame received. Reset mid-TX frame → tx=1, tx_idle=1 immediately.
